// File: rtl/mem_resp_if.sv
// Request/response bundle between the control unit and the data-memory responder.
// The master drives the request fields; the slave drives the result and status.
interface mem_resp_if;
  logic        REQ;
  logic        WR;
  logic [31:0] ADDR;
  logic [1:0]  SIZE;
  logic [63:0] WDATA;
  logic        LOAD_UNSIGNED;
  logic [63:0] RDATA;
  logic        DONE;
  logic        ERR;
  logic        BUSY;

  modport master (
    output REQ,
    output WR,
    output ADDR,
    output SIZE,
    output WDATA,
    output LOAD_UNSIGNED,
    input  RDATA,
    input  DONE,
    input  ERR,
    input  BUSY
  );

  modport slave (
    input  REQ,
    input  WR,
    input  ADDR,
    input  SIZE,
    input  WDATA,
    input  LOAD_UNSIGNED,
    output RDATA,
    output DONE,
    output ERR,
    output BUSY
  );
endinterface

// File: rtl/mem_resp.sv
// Multicycle data-memory responder with wait states and byte-lane selection.
// Define MEM_RESP_SIGN_EXT_EN to sign-extend sub-doubleword loads.
module mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      CLK,
  input  logic      RESET,
  mem_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int AW = IW + 3;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd8;

  logic [63:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

`ifdef MEM_RESP_SIGN_EXT_EN
  logic        uns_q, uns_d;
`else
  logic        unused_uns;
  assign unused_uns = bus.LOAD_UNSIGNED;
`endif

  function automatic logic misal(
    input logic [2:0] off,
    input logic [1:0] sz
  );
    logic r;
    r = 1'b0;
    unique case (sz)
      2'd0: r = 1'b0;
      2'd1: r = off[0];
      2'd2: r = |off[1:0];
      2'd3: r = |off;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] lanes(
    input logic [2:0] off,
    input logic [1:0] sz
  );
    logic [7:0] base;
    base = 8'h00;
    unique case (sz)
      2'd0: base = 8'h01;
      2'd1: base = 8'h03;
      2'd2: base = 8'h0F;
      2'd3: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic [63:0] zsel(
    input logic [63:0] word,
    input logic [2:0]  off,
    input logic [1:0]  sz
  );
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {off, 3'b000};
    r  = sh;
    unique case (sz)
      2'd0: r = {56'd0, sh[7:0]};
      2'd1: r = {48'd0, sh[15:0]};
      2'd2: r = {32'd0, sh[31:0]};
      2'd3: r = sh;
    endcase
    return r;
  endfunction

`ifdef MEM_RESP_SIGN_EXT_EN
  function automatic logic [63:0] sext(
    input logic [63:0] v,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [63:0] r;
    r = v;
    if (sgn) begin
      unique case (sz)
        2'd0: r = {{56{v[7]}}, v[7:0]};
        2'd1: r = {{48{v[15]}}, v[15:0]};
        2'd2: r = {{32{v[31]}}, v[31:0]};
        2'd3: r = v;
      endcase
    end
    return r;
  endfunction
`endif

  logic          req_err;
  logic [IW-1:0] idx;
  logic [2:0]    off;
  logic          commit;
  logic [7:0]    be;
  logic [63:0]   wsh;
  logic [63:0]   ld_val;

  assign req_err = ({1'b0, bus.ADDR} >= LIMIT) ||
                   misal(bus.ADDR[2:0], bus.SIZE);
  assign idx     = addr_q[AW-1:3];
  assign off     = addr_q[2:0];
  assign commit  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign be      = lanes(off, size_q);
  assign wsh     = wdata_q << {off, 3'b000};

`ifdef MEM_RESP_SIGN_EXT_EN
  assign ld_val = sext(zsel(mem_q[idx], off, size_q),
                       size_q, !uns_q);
`else
  assign ld_val = zsel(mem_q[idx], off, size_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MEM_RESP_SIGN_EXT_EN
    uns_d   = uns_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          wr_d    = bus.WR;
          addr_d  = bus.ADDR[AW-1:0];
          size_d  = bus.SIZE;
          wdata_d = bus.WDATA;
`ifdef MEM_RESP_SIGN_EXT_EN
          uns_d   = bus.LOAD_UNSIGNED;
`endif
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 64'd0;
          end else begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = 1'b0;
          if (!wr_q) rdata_d = ld_val;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
`ifdef MEM_RESP_SIGN_EXT_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_RESP_SIGN_EXT_EN
      uns_q   <= uns_d;
`endif
    end
  end

  // Array is never cleared; a reset edge suppresses a pending commit.
  always_ff @(posedge CLK) begin
    if (commit && wr_q && !RESET) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  assign bus.RDATA = rdata_q;
  assign bus.ERR   = err_q;
  assign bus.DONE  = (state_q == RESP);
  assign bus.BUSY  = (state_q != IDLE);

endmodule
